ahb_lite_mem_responder: RTL and testbench

AHB-Lite slave memory model with programmable wait states and error responses. It is the responder end for the AHB-Lite read/write test master in SDRAM controller hardware tests. It stands in for the SDRAM controller so the master, its address stepping and its error counting can be checked standalone. It also serves as a reference slave for bus-level simulation.

---
 rtl/ahb_lite_mem_responder.sv | 164 ++++++++++++++++
 tb/tb_ahb_lite_mem_responder.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_mem_responder.sv
// AHB-Lite memory slave with programmable wait states and two-cycle ERROR responses.
// Stands in for a real memory controller so a bus master can be exercised on its own.
module ahb_lite_mem_responder #(
  parameter int unsigned ADDR_BITS   = 8,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADY,
  output logic        HRESP,
  output logic [15:0] WRCOUNT,
  output logic [15:0] RDCOUNT,
  output logic [15:0] ERRCOUNT
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_LAST,
    ST_ERR1,
    ST_ERR2
  } state_e;

  localparam int unsigned MEM_WORDS = 1 << ADDR_BITS;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

  state_e                 state_q;
  logic [3:0]             cnt_q;
  logic                   isWrite_q;
  logic [ADDR_BITS-1:0]   idx_q;
  logic                   hready_q;
  logic                   hresp_q;
  logic [31:0]            hrdata_q;
  logic [15:0]            wrCount_q;
  logic [15:0]            rdCount_q;
  logic [15:0]            errCount_q;

  logic [31:0]            mem [MEM_WORDS];

  logic                   accept_d;
  logic                   legal_d;
  logic                   writeEn_d;
  logic                   loadRd_d;
  logic [31:0]            offset_d;
  logic [31:0]            rdWord_d;
  logic [ADDR_BITS-1:0]   idx_d;
  logic [ADDR_BITS-1:0]   rdIdx_d;

  // Burst type is ignored and HTRANS[0] only distinguishes SEQ from NONSEQ.
  logic unusedInputs;
  assign unusedInputs = ^{HBURST, HTRANS[0]};

  // Address-phase decode, write commit and read-data selection (with write-to-read forwarding).
  always_comb begin
    accept_d  = hready_q && HSEL && HTRANS[1];
    offset_d  = HADDR - BASE_ADDR;
    legal_d   = (HSIZE == 3'b010) && (HADDR[1:0] == 2'b00) &&
                (HADDR >= BASE_ADDR) && ((offset_d >> (ADDR_BITS + 2)) == 32'd0);
    idx_d     = offset_d[ADDR_BITS+1:2];
    writeEn_d = (state_q == ST_LAST) && isWrite_q && !HRESET;
    loadRd_d  = 1'b0;
    rdIdx_d   = idx_q;
    if ((state_q == ST_WAIT) && (cnt_q == 4'd1) && !isWrite_q) begin
      loadRd_d = 1'b1;
    end else if (accept_d && legal_d && !HWRITE && (WAIT_STATES == 0)) begin
      loadRd_d = 1'b1;
      rdIdx_d  = idx_d;
    end
    if (writeEn_d && (rdIdx_d == idx_q)) begin
      rdWord_d = HWDATA;
    end else begin
      rdWord_d = mem[rdIdx_d];
    end
  end

  // Memory array: written only when a write leaves LAST, never cleared by reset.
  always_ff @(posedge HCLK) begin
    if (writeEn_d) begin
      mem[idx_q] <= HWDATA;
    end
  end

  // Transfer FSM with registered bus outputs and completion counters.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      isWrite_q  <= 1'b0;
      idx_q      <= '0;
      hready_q   <= 1'b1;
      hresp_q    <= 1'b0;
      hrdata_q   <= 32'd0;
      wrCount_q  <= 16'd0;
      rdCount_q  <= 16'd0;
      errCount_q <= 16'd0;
    end else begin
      if (state_q == ST_LAST) begin
        if (isWrite_q) begin
          wrCount_q <= wrCount_q + 16'd1;
        end else begin
          rdCount_q <= rdCount_q + 16'd1;
        end
      end
      if (state_q == ST_ERR2) begin
        errCount_q <= errCount_q + 16'd1;
      end
      if (loadRd_d) begin
        hrdata_q <= rdWord_d;
      end
      case (state_q)
        ST_WAIT: begin
          if (cnt_q == 4'd1) begin
            state_q  <= ST_LAST;
            hready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_ERR1: begin
          state_q  <= ST_ERR2;
          hready_q <= 1'b1;
          hresp_q  <= 1'b1;
        end
        default: begin
          state_q  <= ST_IDLE;
          hready_q <= 1'b1;
          hresp_q  <= 1'b0;
          if (accept_d) begin
            isWrite_q <= HWRITE;
            idx_q     <= idx_d;
            if (!legal_d) begin
              state_q  <= ST_ERR1;
              hready_q <= 1'b0;
              hresp_q  <= 1'b1;
            end else if (WAIT_STATES == 0) begin
              state_q <= ST_LAST;
            end else begin
              state_q  <= ST_WAIT;
              cnt_q    <= WAIT_INIT;
              hready_q <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  assign HRDATA   = hrdata_q;
  assign HREADY   = hready_q;
  assign HRESP    = hresp_q;
  assign WRCOUNT  = wrCount_q;
  assign RDCOUNT  = rdCount_q;
  assign ERRCOUNT = errCount_q;

endmodule

// File: tb/tb_ahb_lite_mem_responder.sv
// Self-checking bench: two responders (2 wait states, 64K words; 0 wait states, 256 words)
// share the bus wires, and HSEL steers each transfer to one of them.
module tb_ahb_lite_mem_responder;

  typedef struct {
    int          kind;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  size;
  } txn_t;

  typedef struct {
    bit          wr;
    bit          err;
    logic [31:0] data;
    int          waits;
  } exp_t;

  logic        clk = 1'b0;
  logic        hreset;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  int          sel;

  logic [31:0] hrdataA, hrdataB;
  logic        hreadyA, hreadyB, hrespA, hrespB;
  logic [15:0] wrA, rdA, errA, wrB, rdB, errB;

  logic [31:0] obsData;
  logic        obsReady, obsResp;
  logic [15:0] obsWr, obsRd, obsErr;

  txn_t        txnQ[$];
  exp_t        expQ[$];
  logic [31:0] modelMem [int];
  int          expWr[2];
  int          expRd[2];
  int          expErr[2];
  int          assertCount = 0;
  int          failCount = 0;

  // 100 MHz bus clock.
  always #5 clk = ~clk;

  ahb_lite_mem_responder #(.ADDR_BITS(16), .BASE_ADDR(32'h0), .WAIT_STATES(2)) dutA (
    .HCLK(clk), .HRESET(hreset), .HSEL(hsel && (sel == 0)), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HRDATA(hrdataA),
    .HREADY(hreadyA), .HRESP(hrespA), .WRCOUNT(wrA), .RDCOUNT(rdA), .ERRCOUNT(errA)
  );

  ahb_lite_mem_responder #(.ADDR_BITS(8), .BASE_ADDR(32'h0), .WAIT_STATES(0)) dutB (
    .HCLK(clk), .HRESET(hreset), .HSEL(hsel && (sel == 1)), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata), .HRDATA(hrdataB),
    .HREADY(hreadyB), .HRESP(hrespB), .WRCOUNT(wrB), .RDCOUNT(rdB), .ERRCOUNT(errB)
  );

  // Outputs of whichever responder is currently addressed.
  always_comb begin
    obsData  = (sel == 1) ? hrdataB : hrdataA;
    obsReady = (sel == 1) ? hreadyB : hreadyA;
    obsResp  = (sel == 1) ? hrespB  : hrespA;
    obsWr    = (sel == 1) ? wrB     : wrA;
    obsRd    = (sel == 1) ? rdB     : rdA;
    obsErr   = (sel == 1) ? errB    : errA;
  end

  // Hard stop in case the bench itself stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running, required finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    assertCount++;
    if (got !== want) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic addTxn(input int kind, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] size);
    txn_t t;
    t.kind = kind; t.wr = wr; t.addr = addr; t.wdata = wdata; t.size = size;
    txnQ.push_back(t);
  endtask

  // Reference model: decides legality and the expected response when an address is accepted.
  function automatic exp_t modelAccept(input txn_t t);
    exp_t        e;
    logic [31:0] a;
    logic [31:0] limit;
    int          key;
    a     = t.addr;
    limit = (sel == 1) ? 32'd1024 : 32'h0004_0000;
    key   = (sel == 1) ? 100000 + int'(a >> 2) : int'(a >> 2);
    e.wr    = t.wr;
    e.err   = !((t.size == 3'b010) && (a[1:0] == 2'b00) && (a < limit));
    e.waits = e.err ? 1 : ((sel == 1) ? 0 : 2);
    e.data  = t.wdata;
    if (!e.err) begin
      if (t.wr) begin
        modelMem[key] = t.wdata;
      end else if (modelMem.exists(key)) begin
        e.data = modelMem[key];
      end else begin
        e.data = 32'hxxxx_xxxx;
      end
    end
    return e;
  endfunction

  // Pipelined master: entered and left just after a rising edge.
  task automatic applyStimulus();
    txn_t cur;
    exp_t head;
    int   waits = 0;
    bit   firstResp = 1'b0;
    bit   haveAddr;
    int   guard = 0;
    while ((txnQ.size() > 0 || expQ.size() > 0) && guard < 2000) begin
      guard++;
      haveAddr = (txnQ.size() > 0);
      if (haveAddr) begin
        cur    = txnQ[0];
        hsel   = (cur.kind != 2);
        htrans = (cur.kind == 1) ? 2'b00 : 2'b10;
        hwrite = cur.wr;
        haddr  = cur.addr;
        hsize  = cur.size;
      end else begin
        hsel   = 1'b0;
        htrans = 2'b00;
      end
      hwdata = (expQ.size() > 0 && expQ[0].wr) ? expQ[0].data : 32'd0;
      @(negedge clk);
      if (expQ.size() > 0) begin
        head = expQ[0];
        if (waits == 0) firstResp = obsResp;
        if (!obsReady) begin
          waits++;
          if (waits > 20) begin
            checkOutput("waitBound", waits, 20);
            txnQ.delete();
            expQ.delete();
            break;
          end
        end else begin
          void'(expQ.pop_front());
          checkOutput("waitCycles", waits, head.waits);
          checkOutput("firstResp", firstResp, head.err);
          checkOutput("lastResp", obsResp, head.err);
          if (!head.wr && !head.err) checkOutput("readData", obsData, head.data);
          if (head.err) expErr[sel]++;
          else if (head.wr) expWr[sel]++;
          else expRd[sel]++;
          waits = 0;
        end
      end else begin
        checkOutput("idleReady", obsReady, 1);
        checkOutput("idleResp", obsResp, 0);
        checkOutput("idleWrCount", obsWr, expWr[sel]);
        checkOutput("idleRdCount", obsRd, expRd[sel]);
        checkOutput("idleErrCount", obsErr, expErr[sel]);
      end
      if (obsReady && haveAddr) begin
        void'(txnQ.pop_front());
        if (cur.kind == 0) expQ.push_back(modelAccept(cur));
      end
      @(posedge clk);
      #1;
    end
    checkOutput("seqDrained", txnQ.size() + expQ.size(), 0);
    hsel   = 1'b0;
    htrans = 2'b00;
  endtask

  initial begin
    hreset = 1'b1; hsel = 1'b0; haddr = 32'd0; htrans = 2'b00; hwrite = 1'b0;
    hsize = 3'b010; hburst = 3'b000; hwdata = 32'd0; sel = 0;
    for (int i = 0; i < 2; i++) begin expWr[i] = 0; expRd[i] = 0; expErr[i] = 0; end
    repeat (3) @(posedge clk);
    #1 hreset = 1'b0;

    // Reset values on both responders.
    @(negedge clk);
    checkOutput("rstReadyA", hreadyA, 1);
    checkOutput("rstRespA", hrespA, 0);
    checkOutput("rstDataA", hrdataA, 32'd0);
    checkOutput("rstWrA", wrA, 0);
    checkOutput("rstRdA", rdA, 0);
    checkOutput("rstErrA", errA, 0);
    checkOutput("rstReadyB", hreadyB, 1);
    checkOutput("rstDataB", hrdataB, 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) addTxn(1, 1'b0, 32'd0, 32'd0, 3'b010);
    applyStimulus();
    checkOutput("idleDataA", hrdataA, 32'd0);

    // Two wait states: pipelined writes with data = address, then read back.
    sel = 0;
    addTxn(0, 1'b1, 32'h0000_0000, 32'h0000_0000, 3'b010);
    addTxn(0, 1'b1, 32'h0001_0004, 32'h0001_0004, 3'b010);
    addTxn(0, 1'b1, 32'h0002_0008, 32'h0002_0008, 3'b010);
    addTxn(0, 1'b0, 32'h0000_0000, 32'd0, 3'b010);
    addTxn(0, 1'b0, 32'h0001_0004, 32'd0, 3'b010);
    addTxn(0, 1'b0, 32'h0002_0008, 32'd0, 3'b010);
    applyStimulus();
    checkOutput("w2WrCount", wrA, 3);
    checkOutput("w2RdCount", rdA, 3);
    checkOutput("w2ErrCount", errA, 0);

    // Zero wait states: back-to-back write then read of the same word.
    sel = 1;
    addTxn(0, 1'b1, 32'h0000_0014, 32'hDEAD_BEEF, 3'b010);
    addTxn(0, 1'b0, 32'h0000_0014, 32'd0, 3'b010);
    addTxn(0, 1'b1, 32'h0000_03FC, 32'h5A5A_00FF, 3'b010);
    addTxn(0, 1'b1, 32'h0000_0018, 32'h0BAD_F00D, 3'b010);
    addTxn(0, 1'b0, 32'h0000_03FC, 32'd0, 3'b010);
    addTxn(0, 1'b0, 32'h0000_0014, 32'd0, 3'b010);
    applyStimulus();
    checkOutput("w0WrCount", wrB, 3);
    checkOutput("w0RdCount", rdB, 3);

    // Error responses: out of range, misaligned, wrong size; memory must be untouched.
    sel = 0;
    addTxn(0, 1'b0, 32'h0004_0000, 32'd0, 3'b010);
    addTxn(0, 1'b0, 32'h0000_0002, 32'd0, 3'b010);
    addTxn(0, 1'b0, 32'h0000_0010, 32'd0, 3'b001);
    applyStimulus();
    checkOutput("errCount3", errA, 3);
    addTxn(0, 1'b1, 32'h0001_0004, 32'hFFFF_0000, 3'b000);
    addTxn(0, 1'b0, 32'h0001_0004, 32'd0, 3'b010);
    addTxn(0, 1'b0, 32'h0000_0000, 32'd0, 3'b010);
    applyStimulus();

    // Reset during the wait states of a write aborts it.
    addTxn(0, 1'b1, 32'h0000_001C, 32'hCAFE_0007, 3'b010);
    applyStimulus();
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h0000_001C; hsize = 3'b010;
    @(negedge clk);
    checkOutput("abortAccept", hreadyA, 1);
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'h1234_5678;
    @(negedge clk);
    checkOutput("abortWaiting", hreadyA, 0);
    @(posedge clk); #1;
    hreset = 1'b1;
    @(posedge clk); #1;
    hreset = 1'b0;
    @(negedge clk);
    checkOutput("abortReady", hreadyA, 1);
    checkOutput("abortResp", hrespA, 0);
    checkOutput("abortWrCount", wrA, 0);
    checkOutput("abortData", hrdataA, 32'd0);
    for (int i = 0; i < 2; i++) begin expWr[i] = 0; expRd[i] = 0; expErr[i] = 0; end
    @(posedge clk); #1;
    addTxn(0, 1'b0, 32'h0000_001C, 32'd0, 3'b010);
    applyStimulus();

    // Idle and deselected cycles interleaved with writes on both responders.
    addTxn(0, 1'b1, 32'h0000_0100, 32'h1111_0100, 3'b010);
    addTxn(1, 1'b0, 32'h0000_0104, 32'd0, 3'b010);
    addTxn(0, 1'b1, 32'h0000_0104, 32'h2222_0104, 3'b010);
    addTxn(2, 1'b1, 32'h0000_0108, 32'hEEEE_EEEE, 3'b010);
    addTxn(1, 1'b0, 32'h0000_0108, 32'd0, 3'b010);
    addTxn(0, 1'b0, 32'h0000_0104, 32'd0, 3'b010);
    applyStimulus();
    checkOutput("mixWrCountA", wrA, 2);
    sel = 1;
    addTxn(0, 1'b1, 32'h0000_0020, 32'h3333_0020, 3'b010);
    addTxn(2, 1'b1, 32'h0000_0020, 32'hEEEE_EEEE, 3'b010);
    addTxn(1, 1'b1, 32'h0000_0020, 32'hEEEE_EEEE, 3'b010);
    addTxn(0, 1'b0, 32'h0000_0020, 32'd0, 3'b010);
    addTxn(0, 1'b0, 32'h0000_0018, 32'd0, 3'b010);
    applyStimulus();
    checkOutput("mixWrCountB", wrB, 1);
    checkOutput("mixRdCountB", rdB, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
